// File: rtl/fp32_mul_pkg.sv
// rtl/fp32_mul_pkg.sv - shared types, constants and operand classifier for the FP32 multiplier shell
package fp32_mul_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

   typedef enum logic [1:0] {
      EXC_NONE,
      EXC_ZERO,
      EXC_INF,
      EXC_NAN
   } exc_tag_t;

   // Priority: NaN (incl. Inf x 0) beats Inf, which beats denormal flush-to-zero.
   function automatic exc_tag_t fp32_classify(input logic [31:0] a, input logic [31:0] b);
      logic [EXP_W-1:0] ea, eb;
      logic [MAN_W-1:0] ma, mb;
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_den, b_den;
      ea     = a[MAN_W +: EXP_W];
      eb     = b[MAN_W +: EXP_W];
      ma     = a[MAN_W-1:0];
      mb     = b[MAN_W-1:0];
      a_nan  = (ea == '1) && (ma != '0);
      b_nan  = (eb == '1) && (mb != '0);
      a_inf  = (ea == '1) && (ma == '0);
      b_inf  = (eb == '1) && (mb == '0);
      a_zero = (ea == '0) && (ma == '0);
      b_zero = (eb == '0) && (mb == '0);
      a_den  = (ea == '0) && (ma != '0);
      b_den  = (eb == '0) && (mb != '0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         return EXC_NAN;
      end else if (a_inf || b_inf) begin
         return EXC_INF;
      end else if (a_den || b_den) begin
         return EXC_ZERO;
      end
      return EXC_NONE;
   endfunction

endpackage

// File: rtl/fp32_res_fifo.sv
// rtl/fp32_res_fifo.sv - synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored
module fp32_res_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   // Head is forced to zero while empty so the output word is clean after reset.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fp32_mul_shell.sv
// rtl/fp32_mul_shell.sv - credit-based valid/ready shell around the FP32 pipelined multiplier
// FP32_MUL_EXC_EN adds operand classification with a parallel tag FIFO and special-result substitution.
module fp32_mul_shell
   import fp32_mul_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_a_i,
   input  logic [31:0] in_b_i,
   output logic        mul_valid_o,
   output logic [31:0] mul_a_o,
   output logic [31:0] mul_b_o,
   input  logic [31:0] mul_result_i,
   input  logic        mul_done_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_result_o,
   output logic        out_exc_o,
   output logic        busy_o,
   output logic        ovf_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH);
`ifdef FP32_MUL_EXC_EN
   localparam int RES_W = 33;
`else
   localparam int RES_W = 32;
`endif

   logic             mul_valid_q, mul_valid_d;
   logic [31:0]      mul_a_q, mul_a_d;
   logic [31:0]      mul_b_q, mul_b_d;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic             ovf_q, ovf_d;
   logic             accept, done_live, res_push, res_pop;
   logic             res_full, res_empty;
   logic [CW-1:0]    res_count;
   logic [CW:0]      occ;
   logic [RES_W-1:0] res_wdata, res_rdata;

   // inflight counts from accept, so the issue-register slot already holds a credit.
   assign occ         = {1'b0, inflight_q} + {1'b0, res_count};
   assign in_ready_o  = (occ < OCC_MAX);
   assign accept      = in_valid_i & in_ready_o;
   assign done_live   = mul_done_i & (inflight_q != '0);
   assign res_push    = done_live & ~res_full;
   assign out_valid_o = ~res_empty;
   assign res_pop     = out_valid_o & out_ready_i;
   assign busy_o      = (occ != '0);
   assign ovf_o       = ovf_q;
   assign mul_valid_o = mul_valid_q;
   assign mul_a_o     = mul_a_q;
   assign mul_b_o     = mul_b_q;

   always_comb begin
      mul_valid_d = accept;
      mul_a_d     = accept ? in_a_i : mul_a_q;
      mul_b_d     = accept ? in_b_i : mul_b_q;
      inflight_d  = inflight_q + CW'(accept) - CW'(done_live);
      ovf_d       = ovf_q | (mul_done_i & ((inflight_q == '0) | res_full));
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mul_valid_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         inflight_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         mul_valid_q <= mul_valid_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         inflight_q  <= inflight_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef FP32_MUL_EXC_EN
   logic [2:0]    tag_wdata, tag_rdata;
   logic          tag_full, tag_empty;
   logic [CW-1:0] tag_count;
   logic          unused_tag;
   exc_tag_t      tag_kind;

   // Tag word is {product sign, class}; popped on every live done so it stays aligned with results.
   assign tag_wdata  = {in_a_i[31] ^ in_b_i[31], 2'(fp32_classify(in_a_i, in_b_i))};
   assign tag_kind   = exc_tag_t'(tag_rdata[1:0]);
   assign unused_tag = &{1'b0, tag_full, tag_empty, tag_count};

   fp32_res_fifo #(
      .WIDTH (3),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (accept),
      .wdata_i (tag_wdata),
      .pop_i   (done_live),
      .rdata_o (tag_rdata),
      .full_o  (tag_full),
      .empty_o (tag_empty),
      .count_o (tag_count)
   );

   always_comb begin
      res_wdata = {1'b0, mul_result_i};
      case (tag_kind)
         EXC_NAN:  res_wdata = {1'b1, FP32_QNAN};
         EXC_INF:  res_wdata = {1'b1, tag_rdata[2], FP32_INF[30:0]};
         EXC_ZERO: res_wdata = {1'b1, tag_rdata[2], 31'h0};
         default:  res_wdata = {1'b0, mul_result_i};
      endcase
   end

   assign out_exc_o = res_rdata[32];
`else
   assign res_wdata = mul_result_i;
   assign out_exc_o = 1'b0;
`endif

   assign out_result_o = res_rdata[31:0];

   fp32_res_fifo #(
      .WIDTH (RES_W),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (res_push),
      .wdata_i (res_wdata),
      .pop_i   (res_pop),
      .rdata_o (res_rdata),
      .full_o  (res_full),
      .empty_o (res_empty),
      .count_o (res_count)
   );

endmodule

// File: tb/tb_fp32_mul_shell.sv
// tb/tb_fp32_mul_shell.sv - directed self-checking bench for fp32_mul_shell with a fixed-latency multiplier model
`timescale 1ns/1ps
module tb_fp32_mul_shell;

   localparam int DEPTH   = 8;
   localparam int MUL_LAT = 4;
   localparam logic [101:0] RST_VEC = {1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid, in_ready, out_valid, out_ready, out_exc, busy, ovf;
   logic [31:0] in_a, in_b, out_result;
   logic        mul_valid, mul_done, inj_done;
   logic [31:0] mul_a, mul_b, mul_result;
   wire  [101:0] obs_vec = {in_ready, mul_valid, mul_a, mul_b, out_valid, out_result, out_exc, busy, ovf};

   int n_checks = 0;
   int n_fail   = 0;

   // Hand-computed exact products.
   logic [31:0] tab_a [8] = '{32'h40000000, 32'h3FC00000, 32'h3F800000, 32'h40800000,
                              32'hC0000000, 32'h41200000, 32'h3F000000, 32'h40400000};
   logic [31:0] tab_b [8] = '{32'h40400000, 32'h3FC00000, 32'hC0A00000, 32'h3E800000,
                              32'hC0000000, 32'h40A00000, 32'h41800000, 32'hBF400000};
   logic [31:0] tab_p [8] = '{32'h40C00000, 32'h40100000, 32'hC0A00000, 32'h3F800000,
                              32'h40800000, 32'h42480000, 32'h41000000, 32'hC0100000};
   logic [31:0] exp_q [$];

   logic [MUL_LAT-1:0] pv_q;
   logic [31:0]        pr_q [MUL_LAT];

   always #5 clk = ~clk;

   fp32_mul_shell #(.DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_a_i       (in_a),
      .in_b_i       (in_b),
      .mul_valid_o  (mul_valid),
      .mul_a_o      (mul_a),
      .mul_b_o      (mul_b),
      .mul_result_i (mul_result),
      .mul_done_i   (mul_done),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_result_o (out_result),
      .out_exc_o    (out_exc),
      .busy_o       (busy),
      .ovf_o        (ovf)
   );

   // Truncating normal-only multiplier; exact for the table operands.
   function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [22:0] m;
      int          e;
      if (a[30:23] == 8'h0 || b[30:23] == 8'h0) return {a[31] ^ b[31], 31'h0};
      p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 1;
      end else begin
         m = p[45:23];
      end
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pv_q <= '0;
         for (int i = 0; i < MUL_LAT; i++) pr_q[i] <= '0;
      end else begin
         pv_q    <= {pv_q[MUL_LAT-2:0], mul_valid};
         pr_q[0] <= fpmul(mul_a, mul_b);
         for (int i = 1; i < MUL_LAT; i++) pr_q[i] <= pr_q[i-1];
      end
   end

   assign mul_done   = pv_q[MUL_LAT-1] | inj_done;
   assign mul_result = pr_q[MUL_LAT-1];

   task automatic test_reset();
      rstn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; inj_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs_vec !== RST_VEC) begin
         n_fail++; $display("FAIL reset_held: got %h expected %h", obs_vec, RST_VEC);
      end
      rstn = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (obs_vec !== RST_VEC) begin
         n_fail++; $display("FAIL reset_released: got %h expected %h", obs_vec, RST_VEC);
      end
   endtask

   task automatic test_single();
      int pulses = 0, issues = 0, lat = -1;
      logic [31:0] got = '0;
      logic gexc = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid = (cyc == 0); in_a = tab_a[0]; in_b = tab_b[0];
         @(negedge clk);
         if (mul_valid) issues++;
         if (out_valid) begin
            pulses++;
            if (lat < 0) begin lat = cyc; got = out_result; gexc = out_exc; end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
      n_checks++; if (got !== 32'h40C00000) begin n_fail++; $display("FAIL single_result: got %h expected 40c00000", got); end
      n_checks++; if (gexc !== 1'b0) begin n_fail++; $display("FAIL single_exc: got %b expected 0", gexc); end
      n_checks++; if (lat !== MUL_LAT + 2) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, MUL_LAT + 2); end
      n_checks++; if (issues !== 1) begin n_fail++; $display("FAIL single_issues: got %0d expected 1", issues); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int acc = 0, got_n = 0, first = -1, last = -1, drops = 0;
      logic [31:0] e;
      exp_q.delete();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && got_n < 32; cyc++) begin
         in_valid = (acc < 32); in_a = tab_a[acc % 8]; in_b = tab_b[acc % 8];
         @(negedge clk);
         if (in_valid) begin
            if (!in_ready) drops++;
            else begin exp_q.push_back(tab_p[acc % 8]); acc++; end
         end
         if (out_valid) begin
            if (first < 0) first = cyc;
            last = cyc; got_n++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra: got %h expected no result", out_result);
            end else begin
               e = exp_q.pop_front();
               if (out_result !== e) begin n_fail++; $display("FAIL b2b_result: got %h expected %h", out_result, e); end
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++; if (got_n !== 32) begin n_fail++; $display("FAIL b2b_count: got %0d expected 32", got_n); end
      n_checks++; if (drops !== 0) begin n_fail++; $display("FAIL b2b_ready_drop: got %0d expected 0", drops); end
      n_checks++; if (last - first !== 31) begin n_fail++; $display("FAIL b2b_rate: got span %0d expected 31", last - first); end
   endtask

   task automatic test_backpressure();
      int acc = 0, issues = 0, nr_cyc = -1, got_n = 0;
      logic [31:0] e;
      exp_q.delete();
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid = 1'b1; in_a = tab_a[acc % 8]; in_b = tab_b[acc % 8];
         @(negedge clk);
         if (mul_valid) issues++;
         if (in_ready) begin exp_q.push_back(tab_p[acc % 8]); acc++; end
         else if (nr_cyc < 0) nr_cyc = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++; if (acc !== DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", acc, DEPTH); end
      n_checks++; if (nr_cyc !== DEPTH) begin n_fail++; $display("FAIL bp_ready_fall: got cycle %0d expected %0d", nr_cyc, DEPTH); end
      n_checks++; if (issues !== DEPTH) begin n_fail++; $display("FAIL bp_issues: got %0d expected %0d", issues, DEPTH); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b expected 0", in_ready); end
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && got_n < DEPTH; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            got_n++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            n_checks++;
            if (out_result !== e) begin n_fail++; $display("FAIL bp_drain_result: got %h expected %h", out_result, e); end
         end
         @(posedge clk); #1;
      end
      n_checks++; if (got_n !== DEPTH) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected %0d", got_n, DEPTH); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL bp_ovf: got %b expected 0", ovf); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy: got %b expected 0", busy); end
   endtask

   task automatic test_random();
      int acc = 0, got_n = 0, issues = 0, cyc = 0, idx = 0;
      logic taken;
      logic [31:0] e;
      exp_q.delete();
      in_valid = 1'b0;
      while (got_n < 1000 && cyc < 20000) begin
         if (!in_valid && acc < 1000 && $urandom_range(0, 3) != 0) begin
            idx = int'($urandom_range(0, 7));
            in_valid = 1'b1; in_a = tab_a[idx]; in_b = tab_b[idx];
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (mul_valid) issues++;
         taken = in_valid & in_ready;
         if (taken) begin exp_q.push_back(tab_p[idx]); acc++; end
         if (out_valid && out_ready) begin
            got_n++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            n_checks++;
            if (out_result !== e) begin n_fail++; $display("FAIL rand_result: got %h expected %h at op %0d", out_result, e, got_n); end
         end
         @(posedge clk); #1;
         if (taken) in_valid = 1'b0;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_checks++; if (got_n !== 1000) begin n_fail++; $display("FAIL rand_count: got %0d expected 1000", got_n); end
      n_checks++; if (acc !== 1000) begin n_fail++; $display("FAIL rand_accepts: got %0d expected 1000", acc); end
      n_checks++; if (issues !== acc) begin n_fail++; $display("FAIL rand_issues: got %0d expected %0d", issues, acc); end
      n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_leftover: got %0d expected 0", exp_q.size()); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rand_ovf: got %b expected 0", ovf); end
   endtask

`ifdef FP32_MUL_EXC_EN
   task automatic test_exc();
      logic [31:0] xa [3];
      logic [31:0] xb [3];
      logic [31:0] xp [3];
      int got_n = 0;
      xa = '{32'h7F800000, 32'hFF800000, 32'h00000001};
      xb = '{32'h40000000, 32'h00000000, 32'h40000000};
      xp = '{32'h7F800000, 32'h7FC00000, 32'h00000000};
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && got_n < 3; cyc++) begin
         in_valid = (cyc < 3);
         in_a = xa[cyc % 3]; in_b = xb[cyc % 3];
         @(negedge clk);
         if (out_valid) begin
            n_checks++;
            if (out_result !== xp[got_n]) begin n_fail++; $display("FAIL exc_result: got %h expected %h", out_result, xp[got_n]); end
            n_checks++;
            if (out_exc !== 1'b1) begin n_fail++; $display("FAIL exc_flag: got %b expected 1", out_exc); end
            got_n++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++; if (got_n !== 3) begin n_fail++; $display("FAIL exc_count: got %0d expected 3", got_n); end
   endtask
`endif

   task automatic test_spurious_done();
      out_ready = 1'b1;
      inj_done = 1'b1;
      @(posedge clk); #1;
      inj_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL spur_ovf: got %b expected 1", ovf); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL spur_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spur_busy: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      int acc = 0, stray = 0, got_n = 0;
      logic [31:0] got = '0;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_valid = 1'b1; in_a = tab_a[cyc]; in_b = tab_b[cyc];
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (acc !== 8) begin n_fail++; $display("FAIL rmid_accepts: got %0d expected 8", acc); end
      n_checks++;
      if ({out_valid, busy, out_result} !== {1'b1, 1'b1, tab_p[0]}) begin
         n_fail++; $display("FAIL rmid_buffered: got %b%b %h expected 11 %h", out_valid, busy, out_result, tab_p[0]);
      end
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (obs_vec !== RST_VEC) begin n_fail++; $display("FAIL rmid_reset_vals: got %h expected %h", obs_vec, RST_VEC); end
      rstn = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         if (out_valid || mul_valid) stray++;
         @(posedge clk); #1;
      end
      n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rmid_stale: got %0d expected 0", stray); end
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid = (cyc == 0); in_a = tab_a[6]; in_b = tab_b[6];
         @(negedge clk);
         if (out_valid) begin got_n++; got = out_result; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++; if (got_n !== 1) begin n_fail++; $display("FAIL rmid_next_count: got %0d expected 1", got_n); end
      n_checks++; if (got !== 32'h41000000) begin n_fail++; $display("FAIL rmid_next_result: got %h expected 41000000", got); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_random();
`ifdef FP32_MUL_EXC_EN
      test_exc();
`endif
      test_spurious_done();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
